// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM instruction-fetch sequencer.
// Holds the FSM state enum, address/data widths, interrupt vector
// locations, the reset PC and the interrupt-index-to-vector mapping.
package rom_fetch_pkg;

  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned INT_COUNT  = 2;

  localparam logic [ADDR_WIDTH-1:0] VEC_INT0 = 8'hFF;
  localparam logic [ADDR_WIDTH-1:0] VEC_INT1 = 8'hFE;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 8'h00;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_VALID,
    ST_VEC_RD,
    ST_VEC_WAIT
  } state_t;

  // ROM location holding the target address for interrupt idx
  function automatic logic [ADDR_WIDTH-1:0] int_vector(input logic idx);
    return idx ? VEC_INT1 : VEC_INT0;
  endfunction

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// ROM / core bus bundle for the fetch sequencer.
// master: the fetch controller (drives ROM address, instruction, acks).
// slave : the environment (ROM data, core handshake, branch, interrupts).
interface rom_fetch_ctrl_if;
  import rom_fetch_pkg::*;

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_valid;
  logic                  instr_accept;
  logic                  branch_en;
  logic [ADDR_WIDTH-1:0] branch_addr;
  logic [INT_COUNT-1:0]  int_raise;
  logic [INT_COUNT-1:0]  int_ack;
  logic [ADDR_WIDTH-1:0] return_addr;

  modport master (
    output rom_addr, instr, instr_valid, int_ack, return_addr,
    input  rom_data, instr_accept, branch_en, branch_addr, int_raise
  );

  modport slave (
    input  rom_addr, instr, instr_valid, int_ack, return_addr,
    output rom_data, instr_accept, branch_en, branch_addr, int_raise
  );

endinterface

// File: rtl/rom_fetch_ctrl_int_pend.sv
// Interrupt pending latch, fixed-priority select (bit0 first) and
// one-cycle acknowledge pulse.
// Ports: clk, reset (sync, active-high), raise (requests), take (vector
// taken this cycle), pend_any_c / sel_c (combinational decision inputs
// for the FSM, including same-cycle requests), ack (registered pulse).
module rom_fetch_int_pend
  import rom_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INT_COUNT-1:0] raise,
  input  logic                 take,
  output logic                 pend_any_c,
  output logic                 sel_c,
  output logic [INT_COUNT-1:0] ack
);

  logic [INT_COUNT-1:0] pend;
  logic [INT_COUNT-1:0] pend_all_c;
  logic [INT_COUNT-1:0] sel_oh_c;

  // Same-cycle requests participate in the decision
  assign pend_all_c = pend | raise;
  assign pend_any_c = |pend_all_c;
  assign sel_c      = ~pend_all_c[0];
  assign sel_oh_c   = pend_all_c[0] ? 2'b01 : 2'b10;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      ack  <= '0;
    end else begin
      ack  <= take ? sel_oh_c : '0;
      pend <= take ? (pend_all_c & ~sel_oh_c) : pend_all_c;
    end
  end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer for a 256x8 program ROM with one-cycle
// registered read latency. Owns the PC, presents each byte through a
// valid/accept handshake, handles branches and vectored interrupts.
// Ports: clk, reset (sync, active-high), bus (rom_fetch_ctrl_if.master).
// Macro ROM_FETCH_INT_EN compiles in interrupt pending/vector logic;
// without it int_raise is ignored and int_ack/return_addr read zero.
module rom_fetch_ctrl
  import rom_fetch_pkg::*;
(
  input logic              clk,
  input logic              reset,
  rom_fetch_ctrl_if.master bus
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_valid;
  logic [ADDR_WIDTH-1:0] next_pc_c;

  // Wraps 0xFF -> 0x00 by width truncation
  assign next_pc_c = bus.branch_en ? bus.branch_addr : ADDR_WIDTH'(pc + 1'b1);

  assign bus.rom_addr    = rom_addr;
  assign bus.instr       = instr;
  assign bus.instr_valid = instr_valid;

`ifdef ROM_FETCH_INT_EN
  logic                  int_pend_c;
  logic                  int_sel_c;
  logic                  int_take_c;
  logic [INT_COUNT-1:0]  int_ack;
  logic [ADDR_WIDTH-1:0] return_addr;

  assign int_take_c = (state == ST_VALID) && bus.instr_accept && int_pend_c;

  rom_fetch_int_pend u_int_pend (
    .clk        (clk),
    .reset      (reset),
    .raise      (bus.int_raise),
    .take       (int_take_c),
    .pend_any_c (int_pend_c),
    .sel_c      (int_sel_c),
    .ack        (int_ack)
  );

  assign bus.int_ack     = int_ack;
  assign bus.return_addr = return_addr;
`else
  logic unused_int_raise_c;
  assign unused_int_raise_c = ^bus.int_raise;
  assign bus.int_ack        = '0;
  assign bus.return_addr    = '0;
`endif

  // Fetch FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      rom_addr    <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
`ifdef ROM_FETCH_INT_EN
      return_addr <= '0;
`endif
    end else begin
      case (state)
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          instr       <= bus.rom_data;
          instr_valid <= 1'b1;
          state       <= ST_VALID;
        end
        ST_VALID: begin
          if (bus.instr_accept) begin
            instr_valid <= 1'b0;
`ifdef ROM_FETCH_INT_EN
            if (int_pend_c) begin
              return_addr <= next_pc_c;
              rom_addr    <= int_vector(int_sel_c);
              state       <= ST_VEC_RD;
            end else
`endif
            begin
              pc       <= next_pc_c;
              rom_addr <= next_pc_c;
              state    <= ST_FETCH;
            end
          end
        end
`ifdef ROM_FETCH_INT_EN
        ST_VEC_RD: state <= ST_VEC_WAIT;
        ST_VEC_WAIT: begin
          pc       <= bus.rom_data;
          rom_addr <= bus.rom_data;
          state    <= ST_FETCH;
        end
`endif
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Scoreboard bench for rom_fetch_ctrl: the driver updates a behavioural
// PC/pending model on each handshake and queues expected bytes and
// interrupt acks; a negedge monitor pops and compares them.
module tb_rom_fetch_ctrl;
  import rom_fetch_pkg::*;

`ifdef ROM_FETCH_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rom_fetch_ctrl_if bus();

  rom_fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ROM with one-cycle registered read
  logic [7:0] mem [256];
  always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] pc_m;
  logic [7:0] ret_m;
  logic [1:0] pend_m;
  logic [7:0] exp_q [$];
  logic [1:0] ack_q [$];
  logic [7:0] rta_q [$];

  task automatic do_reset();
    reset = 1'b1;
    bus.instr_accept = 1'b0;
    bus.branch_en    = 1'b0;
    bus.branch_addr  = 8'h00;
    bus.int_raise    = 2'b00;
    @(posedge clk); #1;
    reset  = 1'b0;
    pc_m   = 8'h00;
    ret_m  = 8'h00;
    pend_m = 2'b00;
    exp_q.delete();
    ack_q.delete();
    rta_q.delete();
    exp_q.push_back(mem[8'h00]);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h00);
    chk("rst_instr", 32'(bus.instr), 32'h00);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_int_ack", 32'(bus.int_ack), 32'h0);
    chk("rst_return_addr", 32'(bus.return_addr), 32'h00);
  endtask

  // Drive one cycle; model advances if the handshake completes
  task automatic cycle(input logic acc, input logic br, input logic [7:0] ba, input logic [1:0] rs);
    logic [1:0] pall;
    logic [1:0] oh;
    logic [7:0] nxt;
    logic [7:0] ea;
    logic       took;
    bus.instr_accept = acc;
    bus.branch_en    = br;
    bus.branch_addr  = ba;
    bus.int_raise    = rs;
    took = acc && bus.instr_valid;
    pall = INT_EN ? (pend_m | rs) : 2'b00;
    ea   = 8'h00;
    if (took) begin
      nxt = br ? ba : 8'(pc_m + 8'd1);
      if (pall != 2'b00) begin
        oh = pall[0] ? 2'b01 : 2'b10;
        ea = pall[0] ? 8'hFF : 8'hFE;
        ack_q.push_back(oh);
        rta_q.push_back(nxt);
        ret_m = nxt;
        pall  = pall & ~oh;
        pc_m  = mem[ea];
      end else begin
        pc_m = nxt;
        ea   = nxt;
      end
      exp_q.push_back(mem[pc_m]);
    end
    pend_m = pall;
    @(posedge clk); #1;
    if (took) chk("rom_addr_after_accept", 32'(bus.rom_addr), 32'(ea));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.instr_valid && n < 20) begin
      cycle(1'b0, 1'b0, 8'h00, 2'b00);
      n++;
    end
    chk("wait_valid", 32'(bus.instr_valid), 32'h1);
  endtask

  // Monitor: new presentations pop expected bytes; held bytes must not move
  logic       prev_v = 1'b0;
  logic [7:0] cur_m  = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e8;
    logic [1:0] e2;
    if (bus.instr_valid) begin
      if (!prev_v) begin
        if (exp_q.size() == 0) chk("instr_unexpected", 32'(bus.instr_valid), 32'h0);
        else begin
          cur_m = exp_q.pop_front();
          chk("instr", 32'(bus.instr), 32'(cur_m));
        end
      end else begin
        chk("instr_stable", 32'(bus.instr), 32'(cur_m));
      end
    end
    prev_v = bus.instr_valid;
    if (bus.int_ack != 2'b00) begin
      if (ack_q.size() == 0) chk("int_ack_unexpected", 32'(bus.int_ack), 32'h0);
      else begin
        e2 = ack_q.pop_front();
        e8 = rta_q.pop_front();
        chk("int_ack", 32'(bus.int_ack), 32'(e2));
        chk("return_addr", 32'(bus.return_addr), 32'(e8));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hA1;
    mem[8'h01] = 8'hB2;
    mem[8'h02] = 8'hC3;
    mem[8'hFF] = 8'h40;
    mem[8'hFE] = 8'h60;

    // Linear fetch, accept held high: valid exactly on cycles 2, 5, 8
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b1, 1'b0, 8'h00, 2'b00);
      chk("linear_valid_cycle", 32'(bus.instr_valid), 32'((k % 3) == 2));
    end

    // Stall in VALID for 10 cycles, then one accept
    do_reset();
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 8'h00, 2'b00);
      chk("stall_valid", 32'(bus.instr_valid), 32'h1);
      chk("stall_instr", 32'(bus.instr), 32'hA1);
      chk("stall_rom_addr", 32'(bus.rom_addr), 32'h00);
    end
    cycle(1'b1, 1'b0, 8'h00, 2'b00);
    wait_valid();
    chk("stall_next", 32'(bus.instr), 32'hB2);

    // Branch without accept is ignored; branch to FF then wrap to 00
    cycle(1'b0, 1'b1, 8'h80, 2'b00);
    cycle(1'b1, 1'b1, 8'hFF, 2'b00);
    wait_valid();
    chk("branch_ff_instr", 32'(bus.instr), 32'h40);
    cycle(1'b1, 1'b0, 8'h00, 2'b00);
    chk("wrap_rom_addr", 32'(bus.rom_addr), 32'h00);

    // Interrupt 0 raised while PC=05 waits in VALID
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wait_valid();
      cycle(1'b1, 1'b0, 8'h00, 2'b00);
    end
    wait_valid();
    cycle(1'b0, 1'b0, 8'h00, 2'b01);
    cycle(1'b0, 1'b0, 8'h00, 2'b00);
    cycle(1'b1, 1'b0, 8'h00, 2'b00);
    chk("int_return_06", 32'(bus.return_addr), INT_EN ? 32'h06 : 32'h00);

    // Both interrupts together: 40 first, 60 on the following accept
    wait_valid();
    cycle(1'b1, 1'b0, 8'h00, 2'b11);
    wait_valid();
    cycle(1'b1, 1'b0, 8'h00, 2'b00);

    // Reset while in VEC_WAIT with interrupt 1 still pending
    wait_valid();
    cycle(1'b1, 1'b1, 8'h33, 2'b11);
    cycle(1'b0, 1'b0, 8'h00, 2'b00);
    do_reset();
    wait_valid();
    chk("after_reset_instr", 32'(bus.instr), 32'hA1);
    cycle(1'b1, 1'b0, 8'h00, 2'b00);
    chk("after_reset_no_int", 32'(bus.rom_addr), 32'h01);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            8'($urandom),
            ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
    end

    // Drain and final consistency
    bus.int_raise = 2'b00;
    wait_valid();
    cycle(1'b0, 1'b0, 8'h00, 2'b00);
    chk("end_exp_q_empty", 32'(exp_q.size()), 32'h0);
    chk("end_ack_q_empty", 32'(ack_q.size()), 32'h0);
    chk("end_return_addr", 32'(bus.return_addr), 32'(ret_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Instruction-fetch sequencer for the microprocessor's 256×8 program ROM. Owns the program counter, drives the ROM address bus, and absorbs the ROM's one-cycle registered read latency. Presents each fetched byte to the processor core through a valid/accept handshake, and services branches and two hardware interrupts by reading their vectors from the top of ROM. Sits between the ROM and the processor decode logic.

## Interface
- ADDR_WIDTH, 8, ROM address / PC width
- DATA_WIDTH, 8, ROM word width
- VEC_INT0, 8'hFF, ROM location holding the interrupt-0 target address
- VEC_INT1, 8'hFE, ROM location holding the interrupt-1 target address
- RESET_PC, 8'h00, PC value after reset

- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- ROM_ADDR  out  ADDR_WIDTH  registered address to ROM
- ROM_DATA  in  DATA_WIDTH  ROM registered read data
- INSTR  out  DATA_WIDTH  fetched byte, valid when INSTR_VALID=1
- INSTR_VALID  out  1  fetched byte available
- INSTR_ACCEPT  in  1  core consumes INSTR this cycle
- BRANCH_EN  in  1  with accept: next PC = BRANCH_ADDR
- BRANCH_ADDR  in  ADDR_WIDTH  branch target
- INT_RAISE  in  2  interrupt requests, bit0 highest priority
- INT_ACK  out  2  one-cycle pulse when an interrupt vector is taken
- RETURN_ADDR  out  ADDR_WIDTH  PC the interrupted program resumes at

## Operation
- States: FETCH, WAIT, VALID, VEC_RD, VEC_WAIT.
- FETCH: ROM_ADDR=PC; next WAIT.
- WAIT: ROM_DATA holds word at PC; INSTR<=ROM_DATA; next VALID.
- VALID: INSTR_VALID=1, INSTR stable until accepted. On INSTR_ACCEPT:
  - next PC = BRANCH_EN ? BRANCH_ADDR : PC+1, mod 256 (0xFF+1 → 0x00);
  - if any interrupt pending: RETURN_ADDR<=next PC, ROM_ADDR<=vector, go VEC_RD;
  - otherwise PC<=next PC, ROM_ADDR<=next PC, go FETCH.
- BRANCH_EN without INSTR_ACCEPT is ignored.
- VEC_RD → VEC_WAIT. In VEC_WAIT: PC<=ROM_DATA, ROM_ADDR<=ROM_DATA, go FETCH.
- Pending: pend <= pend | INT_RAISE each cycle. The decision in VALID uses pend|INT_RAISE, so a request arriving in the accept cycle is taken.
- Service order: bit0 before bit1. On entering VEC_RD, INT_ACK[i]=1 for one cycle and pend[i] clears. The other bit stays pending and is taken at the next accept.
- RETURN_ADDR holds its value until the next vector is taken.
- Branch and interrupt in the same accept cycle: RETURN_ADDR = BRANCH_ADDR.

## Timing
- Reset values: ROM_ADDR=RESET_PC, INSTR=0, INSTR_VALID=0, INT_ACK=0, RETURN_ADDR=0, pend=0, PC=RESET_PC, state=FETCH.
- RESET at any state, including VEC_RD/VEC_WAIT, aborts the operation in progress. Takes effect on the next edge with the values above.
- Fetch latency: INSTR_VALID rises 2 cycles after entering FETCH.
- Sustained throughput is one byte per 3 cycles with the core accepting immediately.
- Interrupt entry: accept → VEC_RD → VEC_WAIT → FETCH. The first vectored byte is valid 4 cycles after the accept edge.
- INSTR_VALID is low in every state except VALID.
- INSTR never changes while INSTR_VALID=1 and INSTR_ACCEPT=0.

## Configuration
- Macro: ROM_FETCH_INT_EN.
- Defined:
  - pending register, vector states and INT_ACK/RETURN_ADDR behaviour are compiled in as described.
- Undefined:
  - VEC_RD/VEC_WAIT are absent and INT_RAISE is ignored.
  - INT_ACK is tied to 0 and RETURN_ADDR to 0.
  - Port list is unchanged.

## Structure
- Shared package rom_fetch_pkg holds:
  - the state enum;
  - default vector constants (8'hFF, 8'hFE);
  - RESET_PC;
  - the interrupt-index-to-vector mapping function.
- One sub-module is natural: rom_fetch_int_pend.
  - Contains the pending latch, the priority select and the ack pulse.
  - Instantiated only under ROM_FETCH_INT_EN.

## Test plan
- Linear fetch: ROM[0..2]=A1,B2,C3, accept held 1.
  - INSTR sequence A1,B2,C3.
  - INSTR_VALID high cycles 2, 5, 8 after reset release.
- Stall: accept held 0 for 10 cycles in VALID.
  - INSTR=A1 and INSTR_VALID=1 stable throughout, ROM_ADDR unchanged.
  - One accept then yields B2.
- Branch and wrap:
  - accept with BRANCH_EN=1, BRANCH_ADDR=FF → next INSTR=ROM[FF];
  - plain accept → ROM_ADDR=00.
- Interrupt: ROM[FF]=40, INT_RAISE=01 pulsed one cycle while PC=05 waits in VALID, then accept.
  - INT_ACK=01 for one cycle, RETURN_ADDR=06.
  - Next INSTR=ROM[40].
- Simultaneous interrupts: INT_RAISE=11 with ROM[FE]=60.
  - Vector 40 is taken first with INT_ACK=01.
  - The next accept takes 60 with INT_ACK=10.
- Reset in VEC_WAIT: RESET=1 for one cycle.
  - All outputs return to reset values, pending cleared.
  - Fetch restarts at 00.
